dom1_serpar_ctrl: RTL and testbench

//  Sequencer sitting directly upstream of the byte-serial/parallel tweakey+state buffer
//  (896 bits = 112 bytes). Converts valid/ready byte handshakes into the buffer's
//  wr/rd/en/ken strobes and starts/waits on the masked SKINNY-128-384+ core.
//  One transaction: load NB_IN bytes -> run core -> capture -> unload NB_OUT bytes.

---
 rtl/dom1_serpar_ctrl_pkg.sv | 25 ++
 rtl/dom1_serpar_ctrl.sv | 119 +++++++++++
 tb/tb_dom1_serpar_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dom1_serpar_ctrl_pkg.sv
// Shared definitions for the serial/parallel buffer sequencer: FSM state encodings
// and default transaction sizes for the 896-bit (112-byte) tweakey+state buffer.
// Optional build macro used by the top: DOM1_SERPAR_KEY_RELOAD_EN.
package dom1_serpar_ctrl_pkg;

    // Bytes shifted in per invocation: 2 state shares + 5 tweakey shares
    localparam int NB_IN_DEF  = 112;
    // Bytes shifted out per invocation: 2 masked state shares, MSB first
    localparam int NB_OUT_DEF = 32;
    // Byte-counter width, wide enough for max(NB_IN, NB_OUT)
    localparam int CNT_W_DEF  = 7;
    // Buffer width in bits (seven 128-bit shares)
    localparam int BUF_W      = 128 * 7;

    // Sequencer states; CAP_K is only reachable when key reload is enabled
    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_CAP_S  = 3'd3,
        ST_CAP_K  = 3'd4,
        ST_UNLOAD = 3'd5
    } state_e;

endpackage

// File: rtl/dom1_serpar_ctrl.sv
// Sequencer in front of the byte-serial/parallel buffer and masked SKINNY core:
// load NB_IN bytes -> core_start -> wait core_done -> capture -> unload NB_OUT bytes.
// Latency: core_done -> o_valid is 2 cycles (3 with DOM1_SERPAR_KEY_RELOAD_EN).
// Backpressure: i_ready only in LOAD, o_valid only in UNLOAD; stalls hold the count.
module dom1_serpar_ctrl
    import dom1_serpar_ctrl_pkg::*;
#(
    parameter int NB_IN  = NB_IN_DEF,
    parameter int NB_OUT = NB_OUT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic i_ready,
    output logic o_valid,
    input  logic o_ready,
    output logic core_start,
    input  logic core_done,
    output logic wr,
    output logic rd,
    output logic en,
    output logic ken,
    output logic busy
);

    // Final-beat compare values; the counter is cleared on these, so it never wraps
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(NB_IN - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(NB_OUT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Strobes and handshakes decode straight from state so that a byte is
    // moved in the same cycle its handshake completes.
    always_comb begin
        i_ready    = 1'b0;
        o_valid    = 1'b0;
        core_start = 1'b0;
        wr         = 1'b0;
        rd         = 1'b0;
        en         = 1'b0;
        ken        = 1'b0;
        case (state_q)
            ST_LOAD: begin
                i_ready = 1'b1;
                wr      = i_valid;
            end
            ST_START:  core_start = 1'b1;
            ST_CAP_S:  en         = 1'b1;
`ifdef DOM1_SERPAR_KEY_RELOAD_EN
            ST_CAP_K:  ken        = 1'b1;
`endif
            ST_UNLOAD: begin
                o_valid = 1'b1;
                rd      = o_ready;
            end
            default: ;
        endcase
    end

    // Idle only when sitting in LOAD with no partial load in progress
    always_comb begin
        busy = !((state_q == ST_LOAD) && (cnt_q == '0));
    end

    // Transaction FSM and shared byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (i_valid) begin
                        if (cnt_q == LAST_IN) begin
                            cnt_q   <= '0;
                            state_q <= ST_START;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_START: state_q <= ST_RUN;
                // core_done is only looked at here; elsewhere it is ignored
                ST_RUN: begin
                    if (core_done) begin
                        state_q <= ST_CAP_S;
                    end
                end
                ST_CAP_S: begin
`ifdef DOM1_SERPAR_KEY_RELOAD_EN
                    state_q <= ST_CAP_K;
`else
                    state_q <= ST_UNLOAD;
`endif
                end
`ifdef DOM1_SERPAR_KEY_RELOAD_EN
                ST_CAP_K: state_q <= ST_UNLOAD;
`endif
                ST_UNLOAD: begin
                    if (o_ready) begin
                        if (cnt_q == LAST_OUT) begin
                            cnt_q   <= '0;
                            state_q <= ST_LOAD;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dom1_serpar_ctrl.sv
// Directed bench for dom1_serpar_ctrl with a behavioural 896-bit buffer model.
// Inputs change 1 time unit after the rising edge; outputs are observed at the
// falling edge (strobe counts, buffer model) or 1 unit after the rising edge.
module tb_dom1_serpar_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_valid = 1'b0;
    logic o_ready = 1'b0;
    logic core_done = 1'b0;
    logic i_ready, o_valid, core_start, wr, rd, en, ken, busy;

    dom1_serpar_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .core_start (core_start),
        .core_done  (core_done),
        .wr         (wr),
        .rd         (rd),
        .en         (en),
        .ken        (ken),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Buffer model and strobe monitor
    logic [7:0]   din = 8'h00;
    logic [255:0] core_res = '0;
    logic [895:0] bufm = '0;
    logic [7:0]   outq[$];
    int nwr = 0, nrd = 0, nen = 0, nken = 0, nstart = 0, viol = 0;

    always @(negedge clk) begin
        if ($countones({wr, rd, en, ken}) > 1) viol++;
        if (i_ready && o_valid) viol++;
        if (wr) begin
            nwr++;
            bufm = {bufm[887:0], din};
        end
        if (rd) begin
            nrd++;
            outq.push_back(bufm[895:888]);
            bufm = {bufm[887:0], 8'h00};
        end
        if (en) begin
            nen++;
            bufm[895:640] = core_res;
        end
        if (ken) nken++;
        if (core_start) nstart++;
    end

    function automatic logic [255:0] make_res(input int seed);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[255-8*k -: 8] = 8'(k * 9 + seed);
        return r;
    endfunction

    // Offer n bytes, optionally with i_valid low every other cycle
    task automatic do_load(input int n, input bit gaps, input int seed);
        int sent = 0;
        int cyc = 0;
        bit acc;
        while (sent < n && cyc < 4 * n + 20) begin
            i_valid = gaps ? ~cyc[0] : 1'b1;
            din = 8'(seed + sent * 5);
            @(negedge clk);
            acc = i_valid && i_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        i_valid = 1'b0;
        chk("load_beats", sent, n);
    endtask

    // Entered 1 unit after the edge that moved the FSM into START
    task automatic do_run(input int lat);
        int b = nen;
        chk("start_pulse", core_start, 1);
        @(posedge clk); #1;
        chk("start_one_cycle", core_start, 0);
        chk("run_busy", busy, 1);
        repeat (lat - 1) @(posedge clk);
        #1;
        chk("run_no_en", nen - b, 0);
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        chk("cap_en", en, 1);
        chk("cap_no_ovld", o_valid, 0);
`ifdef DOM1_SERPAR_KEY_RELOAD_EN
        @(posedge clk); #1;
        chk("capk_ken", ken, 1);
        chk("capk_en_low", en, 0);
        chk("capk_no_ovld", o_valid, 0);
`endif
        @(posedge clk); #1;
        chk("unl_ovld", o_valid, 1);
        chk("en_once", nen - b, 1);
        chk("unl_strobes", {en, ken}, 0);
    endtask

    task automatic do_unload(input bit rnd);
        int got = 0;
        int cyc = 0;
        int b = nrd;
        int qb = outq.size();
        bit acc;
        while (got < 32 && cyc < 2000) begin
            o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = o_valid && o_ready;
            @(posedge clk); #1;
            if (acc) got++;
            cyc++;
        end
        o_ready = 1'b0;
        chk("unl_beats", got, 32);
        chk("rd_count", nrd - b, 32);
        chk("back_iready", i_ready, 1);
        chk("back_no_ovld", o_valid, 0);
        chk("back_idle", busy, 0);
        chk("out_count", outq.size() - qb, 32);
        for (int k = 0; k < 32; k++) begin
            if (qb + k < outq.size())
                chk("out_byte", {24'h0, outq[qb+k]}, {24'h0, core_res[255-8*k -: 8]});
        end
    endtask

    initial begin
        int b;
        int be;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_iready", i_ready, 1);
        chk("rst_ovld", o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", core_start, 0);
        chk("rst_strobes", {wr, rd, en, ken}, 0);
        rst = 1'b0;

        // Transaction 1: continuous load, core_done after 40 cycles, random drain
        b = nwr;
        do_load(112, 1'b0, 17);
        chk("t1_wr", nwr - b, 112);
        core_res = make_res(8'hA0);
        do_run(40);
        do_unload(1'b1);

        // core_done while idle must be ignored
        be = nen;
        core_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        core_done = 1'b0;
        chk("idle_done_en", nen - be, 0);
        chk("idle_done_busy", busy, 0);

        // Transaction 2: i_valid toggling during load, full-rate drain
        b = nwr;
        do_load(112, 1'b1, 3);
        chk("t2_wr", nwr - b, 112);
        core_res = make_res(8'h35);
        do_run(5);
        do_unload(1'b0);

        // Reset in the middle of a load, then a clean transaction
        b = nwr;
        do_load(60, 1'b0, 99);
        chk("part_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_iready", i_ready, 1);
        chk("arst_start", core_start, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("part_wr", nwr - b, 60);
        b = nwr;
        do_load(112, 1'b0, 200);
        chk("t3_wr", nwr - b, 112);
        core_res = make_res(8'h5C);
        do_run(12);
        do_unload(1'b1);

        chk("onehot_viol", viol, 0);
        chk("start_total", nstart, 3);
`ifdef DOM1_SERPAR_KEY_RELOAD_EN
        chk("ken_total", nken, 3);
`else
        chk("ken_total", nken, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
